mem_bus_ctrl: RTL and testbench

- Shared-bus memory controller between NREQ line-granular requesters (cache, DMA) and the main-memory model on the C2 bus.
- Round-robin arbitration; one outstanding transaction at a time.
- Serialises each 16-byte line into BUS_SIZE-bit beats. Deserialises read bursts.
- Enforces a response timeout so a silent memory cannot hang a requester.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_bus_ctrl_if.sv | 37 +++
 rtl/mem_bus_ctrl_rr_arbiter.sv | 47 ++++
 rtl/mem_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: C2 bus encoding, controller states and line geometry
// shared by the memory bus controller, its interface and the bench.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      NOP      = 2'd0,
      RESPONSE = 2'd1,
      READ     = 2'd2,
      WRITE    = 2'd3
   } c2_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT,
      RECV,
      DONE
   } ctrl_state_t;

   localparam int MEM_ADDR_SIZE     = 19;
   localparam int CACHE_OFFSET_SIZE = 4;
   localparam int CACHE_LINE_SIZE   = 16;
   localparam int BUS_SIZE          = 16;

   localparam int ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
   localparam int LINE_W = CACHE_LINE_SIZE * 8;
   localparam int BEATS  = LINE_W / BUS_SIZE;
   localparam int BEAT_W = $clog2(BEATS);

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: requester handshake plus C2 memory bus.
// master = controller side, slave = requesters and memory.
interface mem_bus_ctrl_if
   import mem_bus_pkg::*;
#(
   parameter int NREQ = 2
) ();

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_write;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*LINE_W-1:0] req_wdata;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        resp_valid;
   logic [LINE_W-1:0]      resp_rdata;
   logic                   resp_err;
   logic [ADDR_W-1:0]      mem_addr;
   c2_cmd_t                mem_cmd_o;
   logic [BUS_SIZE-1:0]    mem_data_o;
   c2_cmd_t                mem_cmd_i;
   logic [BUS_SIZE-1:0]    mem_data_i;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr, mem_cmd_o, mem_data_o,
      input  mem_cmd_i, mem_data_i
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr, mem_cmd_o, mem_data_o,
      output mem_cmd_i, mem_data_i
   );

endinterface

// File: rtl/mem_bus_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the search starts at ptr_q
// and moves past the winner whenever the grant is consumed.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] ptr_q;
   logic          found;
   int            idx;

   // first requester at or after the pointer wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end

   // pointer moves to the slot after the consumed grant
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (advance && found) begin
         if (grant_idx == IW'(NREQ - 1))
            ptr_q <= '0;
         else
            ptr_q <= grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates line requests onto the C2 bus, one at a
// time, serialising writes and reassembling read bursts.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 255
) (
   input logic           clk,
   input logic           reset,
   mem_bus_ctrl_if.master bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   ctrl_state_t         state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                write_q;
   logic [LINE_W-1:0]   wdata_q;
   logic [LINE_W-1:0]   rline_q;
   logic [IW-1:0]       id_q;
   logic                err_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [TW-1:0]       tmo_q;

   logic [NREQ-1:0]     grant;
   logic [IW-1:0]       grant_idx;
   logic                any_req;
   logic                advance;
   logic                resp_in;
   logic                tmo_hit;
   logic                last_wbeat;
   logic [BEAT_W-1:0]   slot;

   logic [NREQ-1:0]     resp_valid_c;
   c2_cmd_t             cmd_c;
   logic [BUS_SIZE-1:0] data_c;
   logic [ADDR_W-1:0]   addr_c;

   assign any_req    = |bus.req_valid;
   assign advance    = (state_q == IDLE) && any_req && !reset;
   assign resp_in    = (bus.mem_cmd_i == RESPONSE);
   assign tmo_hit    = (tmo_q == TW'(TIMEOUT));
   assign last_wbeat = (beat_q == BEAT_W'(BEATS - 1));
   // beat 0 lands in WAIT, so RECV fills slots one ahead of its count
   assign slot       = beat_q + 1'b1;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (bus.req_valid),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (any_req) state_d = SEND;
         SEND: if (!write_q || last_wbeat) state_d = WAIT;
         WAIT: begin
            if (resp_in)
               state_d = write_q ? DONE : RECV;
            else if (tmo_hit)
               state_d = DONE;
         end
         RECV: begin
            if (!resp_in)
               state_d = DONE;
            else if (beat_q == BEAT_W'(BEATS - 2))
               state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // request latch, beat/timeout counters and read line assembly
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rline_q <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         beat_q  <= '0;
         tmo_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               beat_q <= '0;
               tmo_q  <= '0;
               if (any_req) begin
                  addr_q  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                  write_q <= bus.req_write[grant_idx];
                  wdata_q <= bus.req_wdata[grant_idx*LINE_W +: LINE_W];
                  id_q    <= grant_idx;
                  rline_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            SEND: begin
               tmo_q <= '0;
               if (write_q && !last_wbeat)
                  beat_q <= beat_q + 1'b1;
               else
                  beat_q <= '0;
            end
            WAIT: begin
               beat_q <= '0;
               if (tmo_q != {TW{1'b1}})
                  tmo_q <= tmo_q + 1'b1;
               if (resp_in) begin
                  if (!write_q)
                     rline_q[BUS_SIZE-1:0] <= bus.mem_data_i;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
               end
            end
            RECV: begin
               tmo_q <= '0;
               if (resp_in) begin
                  rline_q[slot*BUS_SIZE +: BUS_SIZE] <= bus.mem_data_i;
                  beat_q <= slot;
               end else begin
                  err_q <= 1'b1;
               end
            end
            DONE: begin
               beat_q <= '0;
               tmo_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   // response pulse to the latched requester
   always_comb begin
      resp_valid_c = '0;
      if (state_q == DONE)
         resp_valid_c[id_q] = 1'b1;
   end

   // C2 command/data serialiser
   always_comb begin
      cmd_c  = NOP;
      data_c = '0;
      addr_c = '0;
      if (state_q == SEND) begin
         addr_c = addr_q;
         if (write_q) begin
            cmd_c  = WRITE;
            data_c = wdata_q[beat_q*BUS_SIZE +: BUS_SIZE];
         end else begin
            cmd_c = READ;
         end
      end
   end

   assign bus.req_ready  = advance ? grant : '0;
   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_rdata = (state_q == DONE) ? rline_q : '0;
   assign bus.resp_err   = (state_q == DONE) && err_q;
   assign bus.mem_cmd_o  = cmd_c;
   assign bus.mem_data_o = data_c;
   assign bus.mem_addr   = addr_c;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: C2 memory responder plus requester-side scenarios
// checked against latency/data rules and a line-level memory model.
module tb_mem_bus_ctrl;
   import mem_bus_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_bus_ctrl_if #(.NREQ(2)) bus ();

   mem_bus_ctrl #(.NREQ(2), .TIMEOUT(255)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mem_k      = 1;
   int mem_nbeats = 8;

   c2_cmd_t           sched_cmd [int];
   logic [15:0]       sched_dat [int];
   logic [LINE_W-1:0] bus_mem [int];
   logic [LINE_W-1:0] ref_mem [int];

   localparam logic [LINE_W-1:0] RD_LINE =
      128'h8888_7777_6666_5555_4444_3333_2222_1111;
   localparam logic [LINE_W-1:0] WR_LINE =
      128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;

   function automatic logic [LINE_W-1:0] init_line(
      input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] l;
      if (a == 15'h0123) return RD_LINE;
      for (int j = 0; j < BEATS; j++)
         l[j*16 +: 16] = {a[11:0], 4'(j)} ^ 16'hA5C3;
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] mem_line(
      input logic [ADDR_W-1:0] a);
      if (bus_mem.exists(int'(a))) return bus_mem[int'(a)];
      return init_line(a);
   endfunction

   // memory model: answers READ after mem_k cycles with mem_nbeats
   // beats, acknowledges a full WRITE line mem_k cycles after beat 7
   initial begin
      logic [LINE_W-1:0] l;
      logic [LINE_W-1:0] wbuf;
      int wcnt;
      wcnt = 0;
      wbuf = '0;
      bus.mem_cmd_i  = NOP;
      bus.mem_data_i = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (sched_cmd.exists(cyc)) begin
            bus.mem_cmd_i  = sched_cmd[cyc];
            bus.mem_data_i = sched_dat[cyc];
            sched_cmd.delete(cyc);
            sched_dat.delete(cyc);
         end else begin
            bus.mem_cmd_i  = NOP;
            bus.mem_data_i = 16'($urandom);
         end
         @(negedge clk);
         if (reset) begin
            sched_cmd.delete();
            sched_dat.delete();
            wcnt = 0;
         end else if (bus.mem_cmd_o == READ) begin
            l = mem_line(bus.mem_addr);
            for (int j = 0; j < mem_nbeats; j++) begin
               sched_cmd[cyc+mem_k+j] = RESPONSE;
               sched_dat[cyc+mem_k+j] = l[j*16 +: 16];
            end
         end else if (bus.mem_cmd_o == WRITE) begin
            wbuf[wcnt*16 +: 16] = bus.mem_data_o;
            wcnt++;
            if (wcnt == BEATS) begin
               bus_mem[int'(bus.mem_addr)] = wbuf;
               wcnt = 0;
               sched_cmd[cyc+mem_k] = RESPONSE;
               sched_dat[cyc+mem_k] = '0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      bus.req_valid = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // issues one request and records what the bus and response show;
   // cycle numbers are relative to the accepting cycle
   task automatic run_txn(
      input  int                rq,
      input  bit                wr,
      input  logic [ADDR_W-1:0] a,
      input  logic [LINE_W-1:0] wd,
      output int                t_rdy,
      output int                n_cmd,
      output int                first_c,
      output int                last_c,
      output c2_cmd_t           kind,
      output int                bad,
      output int                t_resp,
      output logic [1:0]        vec,
      output logic [LINE_W-1:0] rd,
      output logic              er);
      int t0;
      t_rdy = -1; n_cmd = 0; first_c = -1; last_c = -1;
      kind = NOP; bad = 0; t_resp = -1; vec = '0; rd = '0;
      er = 1'b0; t0 = 0;
      bus.req_valid = '0;
      bus.req_valid[rq] = 1'b1;
      bus.req_write[rq] = wr;
      bus.req_addr[rq*ADDR_W +: ADDR_W] = a;
      bus.req_wdata[rq*LINE_W +: LINE_W] = wd;
      for (int c = 0; c < 50 && t_rdy < 0; c++) begin
         @(negedge clk);
         if (bus.req_ready != 0) begin
            t_rdy = c;
            t0 = cyc;
            if (bus.req_ready != 2'(1 << rq)) bad++;
         end
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      for (int c = 0; c < 400 && t_resp < 0; c++) begin
         @(negedge clk);
         if (bus.mem_cmd_o != NOP) begin
            if (n_cmd == 0) begin
               first_c = cyc - t0;
               kind = bus.mem_cmd_o;
            end else if (bus.mem_cmd_o != kind) begin
               bad++;
            end
            n_cmd++;
            last_c = cyc - t0;
            if (bus.mem_addr != a) bad++;
         end else if (bus.mem_data_o != 0) begin
            bad++;
         end
         if (bus.req_ready != 0) bad++;
         if (bus.resp_valid != 0) begin
            t_resp = cyc - t0;
            vec = bus.resp_valid;
            rd = bus.resp_rdata;
            er = bus.resp_err;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 2'b00) begin
         n_fail++; $display("FAIL rst_ready: got %b want 00", bus.req_ready);
      end
      n_tests++;
      if (bus.resp_valid !== 2'b00) begin
         n_fail++; $display("FAIL rst_resp_valid: got %b want 00", bus.resp_valid);
      end
      n_tests++;
      if (bus.resp_rdata !== '0 || bus.resp_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_resp: got %h/%b want 0/0", bus.resp_rdata, bus.resp_err);
      end
      n_tests++;
      if (bus.mem_cmd_o !== NOP || bus.mem_addr !== '0 || bus.mem_data_o !== '0) begin
         n_fail++;
         $display("FAIL rst_mem: got cmd %0d addr %h data %h want 0", bus.mem_cmd_o, bus.mem_addr, bus.mem_data_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      int t_rdy, n_cmd, f, l, bad, t_resp;
      c2_cmd_t kind; logic [1:0] vec; logic [LINE_W-1:0] rd; logic er;
      mem_k = 3; mem_nbeats = 8;
      run_txn(0, 1'b0, 15'h0123, '0, t_rdy, n_cmd, f, l, kind, bad, t_resp, vec, rd, er);
      n_tests++;
      if (kind !== READ || f != 1 || n_cmd != 1) begin
         n_fail++; $display("FAIL rd_cmd: got kind %0d at t%0d x%0d want READ at t1 x1", kind, f, n_cmd);
      end
      n_tests++;
      if (t_resp != 12 || vec !== 2'b01) begin
         n_fail++; $display("FAIL rd_resp: got t%0d vec %b want t12 vec 01", t_resp, vec);
      end
      n_tests++;
      if (rd !== RD_LINE || er !== 1'b0) begin
         n_fail++; $display("FAIL rd_data: got %h err %b want %h err 0", rd, er, RD_LINE);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL rd_bus: got %0d bus violations want 0", bad);
      end
   endtask

   task automatic test_single_write();
      int t_rdy, n_cmd, f, l, bad, t_resp;
      c2_cmd_t kind; logic [1:0] vec; logic [LINE_W-1:0] rd; logic er;
      mem_k = 2; mem_nbeats = 8;
      run_txn(1, 1'b1, 15'h7FFF, WR_LINE, t_rdy, n_cmd, f, l, kind, bad, t_resp, vec, rd, er);
      n_tests++;
      if (kind !== WRITE || f != 1 || l != 8 || n_cmd != 8) begin
         n_fail++; $display("FAIL wr_cmd: got kind %0d t%0d..t%0d x%0d want WRITE t1..t8 x8", kind, f, l, n_cmd);
      end
      n_tests++;
      if (bus_mem[int'(15'h7FFF)] !== WR_LINE) begin
         n_fail++; $display("FAIL wr_beats: got %h want %h", bus_mem[int'(15'h7FFF)], WR_LINE);
      end
      n_tests++;
      if (t_resp != 11 || vec !== 2'b10 || er !== 1'b0 || rd !== '0) begin
         n_fail++; $display("FAIL wr_resp: got t%0d vec %b err %b rd %h want t11 10 0 0", t_resp, vec, er, rd);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL wr_bus: got %0d bus violations want 0", bad);
      end
   endtask

   task automatic test_contention();
      int g[$];
      int r[$];
      int busy, bad;
      busy = 0; bad = 0;
      do_reset();
      mem_k = 1; mem_nbeats = 8;
      bus.req_write = '0;
      bus.req_addr  = {15'h0AAA, 15'h0555};
      bus.req_valid = 2'b11;
      for (int c = 0; c < 200 && r.size() < 4; c++) begin
         @(negedge clk);
         if (bus.req_ready != 0) begin
            if (busy != 0 || !$onehot(bus.req_ready)) bad++;
            g.push_back(bus.req_ready[1] ? 1 : 0);
            busy = 1;
         end
         if (bus.resp_valid != 0) begin
            r.push_back(bus.resp_valid[1] ? 1 : 0);
            busy = 0;
         end
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      n_tests++;
      if (g.size() != 4 || r.size() != 4 || bad != 0) begin
         n_fail++;
         $display("FAIL arb_count: got %0d grants %0d resps %0d bad want 4 4 0", g.size(), r.size(), bad);
      end
      for (int i = 0; i < g.size() && i < r.size(); i++) begin
         n_tests++;
         if (g[i] != i % 2 || r[i] != i % 2) begin
            n_fail++; $display("FAIL arb_order%0d: got grant %0d resp %0d want %0d", i, g[i], r[i], i % 2);
         end
      end
   endtask

   task automatic test_timeout();
      int t_rdy, n_cmd, f, l, bad, t_resp;
      c2_cmd_t kind; logic [1:0] vec; logic [LINE_W-1:0] rd; logic er;
      mem_k = 1; mem_nbeats = 0;
      run_txn(0, 1'b0, 15'h0055, '0, t_rdy, n_cmd, f, l, kind, bad, t_resp, vec, rd, er);
      mem_nbeats = 8;
      n_tests++;
      if (t_resp != 2 + 256 || er !== 1'b1 || vec !== 2'b01) begin
         n_fail++; $display("FAIL tmo_resp: got t%0d err %b vec %b want t258 1 01", t_resp, er, vec);
      end
      n_tests++;
      if (n_cmd != 1 || bad != 0 || rd !== '0) begin
         n_fail++; $display("FAIL tmo_bus: got %0d cmds %0d bad rd %h want 1 0 0", n_cmd, bad, rd);
      end
   endtask

   task automatic test_broken_burst();
      int t_rdy, n_cmd, f, l, bad, t_resp;
      c2_cmd_t kind; logic [1:0] vec; logic [LINE_W-1:0] rd; logic er;
      logic [LINE_W-1:0] exp;
      mem_k = 2; mem_nbeats = 5;
      exp = init_line(15'h0042);
      exp[LINE_W-1:80] = '0;
      run_txn(1, 1'b0, 15'h0042, '0, t_rdy, n_cmd, f, l, kind, bad, t_resp, vec, rd, er);
      mem_nbeats = 8;
      n_tests++;
      if (er !== 1'b1 || t_resp != 2 + 7 || vec !== 2'b10) begin
         n_fail++; $display("FAIL brk_resp: got err %b t%0d vec %b want 1 t9 10", er, t_resp, vec);
      end
      n_tests++;
      if (rd !== exp) begin
         n_fail++; $display("FAIL brk_data: got %h want %h", rd, exp);
      end
   endtask

   task automatic test_reset_mid();
      int t0, quiet;
      int t_rdy, n_cmd, f, l, bad, t_resp;
      c2_cmd_t kind; logic [1:0] vec; logic [LINE_W-1:0] rd; logic er;
      t0 = -1; quiet = 0;
      mem_k = 2; mem_nbeats = 8;
      bus.req_write = '0;
      bus.req_addr[ADDR_W-1:0] = 15'h0333;
      bus.req_valid = 2'b01;
      for (int c = 0; c < 20 && t0 < 0; c++) begin
         @(negedge clk);
         if (bus.req_ready[0]) t0 = cyc;
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      for (int c = 0; c < 20 && cyc < t0 + 6; c++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== '0 || bus.resp_valid !== '0 || bus.resp_err !== 1'b0
          || bus.resp_rdata !== '0 || bus.mem_cmd_o !== NOP
          || bus.mem_addr !== '0 || bus.mem_data_o !== '0) begin
         n_fail++;
         $display("FAIL mid_rst_out: got rv %b cmd %0d addr %h data %h want all 0",
                  bus.resp_valid, bus.mem_cmd_o, bus.mem_addr, bus.mem_data_o);
      end
      @(posedge clk); #1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus.resp_valid != 0) quiet++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (quiet != 0) begin
         n_fail++; $display("FAIL mid_rst_quiet: got %0d resp pulses want 0", quiet);
      end
      run_txn(1, 1'b0, 15'h0444, '0, t_rdy, n_cmd, f, l, kind, bad, t_resp, vec, rd, er);
      n_tests++;
      if (t_resp != 11 || vec !== 2'b10 || er !== 1'b0 || rd !== init_line(15'h0444)) begin
         n_fail++; $display("FAIL mid_rst_reread: got t%0d vec %b err %b rd %h", t_resp, vec, er, rd);
      end
   endtask

   task automatic test_random();
      int rq, k, t_rdy, n_cmd, f, l, bad, t_resp;
      bit wr;
      logic [ADDR_W-1:0] a;
      logic [LINE_W-1:0] wd, exp, rd;
      c2_cmd_t kind; logic [1:0] vec; logic er;
      for (int n = 0; n < 24; n++) begin
         rq = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = 15'h0100 + 15'($urandom_range(0, 7));
         wd = {$urandom, $urandom, $urandom, $urandom};
         k  = int'($urandom_range(1, 5));
         mem_k = k; mem_nbeats = 8;
         if (wr) exp = '0;
         else if (ref_mem.exists(int'(a))) exp = ref_mem[int'(a)];
         else exp = init_line(a);
         run_txn(rq, wr, a, wd, t_rdy, n_cmd, f, l, kind, bad, t_resp, vec, rd, er);
         if (wr) ref_mem[int'(a)] = wd;
         n_tests++;
         if (t_resp != 9 + k || vec !== 2'(1 << rq) || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_resp: got t%0d vec %b err %b want t%0d vec %b err 0",
                     n, t_resp, vec, er, 9 + k, 2'(1 << rq));
         end
         n_tests++;
         if (rd !== exp) begin
            n_fail++; $display("FAIL rnd%0d_data: got %h want %h", n, rd, exp);
         end
         n_tests++;
         if (n_cmd != (wr ? 8 : 1) || kind !== (wr ? WRITE : READ) || bad != 0) begin
            n_fail++; $display("FAIL rnd%0d_bus: got %0d cmds kind %0d bad %0d", n, n_cmd, kind, bad);
         end
         if (wr) begin
            n_tests++;
            if (bus_mem[int'(a)] !== wd) begin
               n_fail++; $display("FAIL rnd%0d_wbeats: got %h want %h", n, bus_mem[int'(a)], wd);
            end
         end
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_timeout();
      test_broken_burst();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
